// File: rtl/fifo_multi_ch_pkg.sv
// Shared defaults and width helpers for the multi-channel FIFO.
package fifo_multi_ch_pkg;

    function automatic int unsigned ch_idx_w(input int unsigned ch_num);
        return $clog2(ch_num);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned addr_size);
        return addr_size + 1;
    endfunction

    localparam int unsigned DATA_SIZE_DEF = 8;
    localparam int unsigned ADDR_SIZE_DEF = 4;
    localparam int unsigned CH_NUM_DEF    = 4;
    localparam int unsigned LVL_W_DEF     = lvl_w(ADDR_SIZE_DEF);

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel pointer pair, status flags and sticky error bits.
module fifo_ch_ctrl
    import fifo_multi_ch_pkg::*;
#(
    parameter int unsigned LVL_W     = LVL_W_DEF,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic             wr_clk,
    input  logic             rd_rst_n,
    input  logic             push_ok,
    input  logic             pop_ok,
    input  logic             ovf_set,
    input  logic             udf_set,
    input  logic             flush_req,
    input  logic             err_clr,
    output logic [LVL_W-2:0] wr_idx,
    output logic [LVL_W-2:0] rd_idx,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam logic [LVL_W-1:0] DEPTH    = LVL_W'(1 << (LVL_W - 1));
    localparam logic [LVL_W-1:0] AFULL_TH = LVL_W'(AFULL_LVL);

    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + LVL_W'(1);
        // Flush discards everything written so far, including any in-flight pop.
        if (flush_req)   rd_ptr_d = wr_ptr_q;
        else if (pop_ok) rd_ptr_d = rd_ptr_q + LVL_W'(1);
        // A set in the same cycle as a clear must win.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;
    end

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == DEPTH);
    assign empty   = (level == '0);
    assign afull   = (level >= AFULL_TH);
    assign wr_idx  = wr_ptr_q[LVL_W-2:0];
    assign rd_idx  = rd_ptr_q[LVL_W-2:0];
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule

// File: rtl/fifo_multi_ch.sv
// Multi-channel same-clock FIFO: shared word array, per-channel control, FWFT read mux.
module fifo_multi_ch
    import fifo_multi_ch_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned CH_NUM    = CH_NUM_DEF,
    parameter int unsigned CH_IDX_W  = ch_idx_w(CH_NUM),
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic                              wr_clk,
    input  logic                              rd_rst_n,
    input  logic                              wr_inc,
    input  logic [CH_IDX_W-1:0]               wr_ch,
    input  logic [DATA_SIZE-1:0]              wr_data,
    input  logic                              rd_inc,
    input  logic [CH_IDX_W-1:0]               rd_ch,
    output logic [DATA_SIZE-1:0]              rd_data,
    output logic                              rd_valid,
    input  logic                              flush,
    input  logic [CH_IDX_W-1:0]               flush_ch,
    input  logic                              err_clr,
    output logic [CH_NUM-1:0]                 full,
    output logic [CH_NUM-1:0]                 empty,
    output logic [CH_NUM-1:0]                 afull,
    output logic [CH_NUM*(ADDR_SIZE+1)-1:0]   level,
    output logic [CH_NUM-1:0]                 ovf_err,
    output logic [CH_NUM-1:0]                 udf_err
);

    localparam int unsigned DEPTH  = 1 << ADDR_SIZE;
    localparam int unsigned LVL_W  = lvl_w(ADDR_SIZE);
    localparam int unsigned ADDR_W = CH_IDX_W + ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [CH_NUM*DEPTH];
    logic [ADDR_SIZE-1:0] wr_idx [CH_NUM];
    logic [ADDR_SIZE-1:0] rd_idx [CH_NUM];
    logic [CH_NUM-1:0]    push_ok;
    logic [CH_NUM-1:0]    pop_ok;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic push_req;
        logic pop_req;
        logic flush_sel;

        assign push_req   = wr_inc && (wr_ch == CH_IDX_W'(n));
        assign pop_req    = rd_inc && (rd_ch == CH_IDX_W'(n));
        assign flush_sel  = flush && (flush_ch == CH_IDX_W'(n));
        // Requests to a channel being flushed are dropped without raising errors.
        assign push_ok[n] = push_req && !full[n] && !flush_sel;
        assign pop_ok[n]  = pop_req && !empty[n] && !flush_sel;

        fifo_ch_ctrl #(
            .LVL_W     (LVL_W),
            .AFULL_LVL (AFULL_LVL)
        ) u_ctrl (
            .wr_clk    (wr_clk),
            .rd_rst_n  (rd_rst_n),
            .push_ok   (push_ok[n]),
            .pop_ok    (pop_ok[n]),
            .ovf_set   (push_req && full[n] && !flush_sel),
            .udf_set   (pop_req && empty[n] && !flush_sel),
            .flush_req (flush_sel),
            .err_clr   (err_clr),
            .wr_idx    (wr_idx[n]),
            .rd_idx    (rd_idx[n]),
            .level     (level[n*LVL_W +: LVL_W]),
            .full      (full[n]),
            .empty     (empty[n]),
            .afull     (afull[n]),
            .ovf_err   (ovf_err[n]),
            .udf_err   (udf_err[n])
        );
    end

    assign wr_addr = {wr_ch, wr_idx[wr_ch]};
    assign rd_addr = {rd_ch, rd_idx[rd_ch]};

    always_ff @(posedge wr_clk) begin
        if (|push_ok) mem[wr_addr] <= wr_data;
    end

    assign rd_data  = mem[rd_addr];
    assign rd_valid = !empty[rd_ch];

endmodule
